mem_responder: RTL

- Memory-side responder for the datapath's memory interface. The datapath (MAR/MDR plus the Read/Write strobes from control) is the initiator; this block is the responder.
- Services reads and writes to a word-addressed 32-bit RAM after a programmable latency.
- Returns read data on Mdatain (the bus the datapath's MDR mux loads when Read is high) and signals completion with Done.
- Sits between the datapath's MAR/MDR outputs and its MDatain input; control waits on Done before de-asserting MDRin.

---
 rtl/mem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder
// -------------
// Memory-side responder for the datapath memory interface. Read/Write strobes
// from control are edge-detected; a single request is captured in IDLE, waits
// LAT clock cycles, and then completes against a word-addressed 32-bit RAM
// with a one-cycle Done pulse.
//
// Ports:
//   clk      system clock, rising edge
//   clr      synchronous active-high reset (RAM contents are preserved)
//   Read     read strobe from control
//   Write    write strobe from control
//   MARaddr  word address (low ADDR_W bits of MAR)
//   MDRdata  write data from MDR
//   Mdatain  read data to the MDR input mux, held until the next read completes
//   Done     one-cycle completion pulse
//   Busy     access in progress
//   Err      one-cycle pulse when Read and Write are requested together in IDLE
module mem_responder #(
    parameter int ADDR_W = 9,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] MARaddr,
    input  logic [31:0]       MDRdata,
    output logic [31:0]       Mdatain,
    output logic              Done,
    output logic              Busy,
    output logic              Err
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    // Counter preload; LAT is limited to 1..15 so it fits in four bits.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nxt_s;
    logic              read_prev_r;
    logic              write_prev_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       data_r;
    logic              op_wr_r;
    logic [31:0]       ram_r [0:DEPTH-1];

    logic req_rd_s;
    logic req_wr_s;
    logic can_accept_s;
    logic start_s;
    logic err_s;
    logic ram_we_s;

    assign req_rd_s = Read & ~read_prev_r;
    assign req_wr_s = Write & ~write_prev_r;

    // A new request is taken in IDLE and also on the edge leaving RESP so
    // back-to-back accesses need no idle cycle in between.
    assign can_accept_s = (state_r == ST_IDLE) || (state_r == ST_RESP);
    assign start_s      = can_accept_s & (req_rd_s ^ req_wr_s);
    assign err_s        = (state_r == ST_IDLE) & req_rd_s & req_wr_s;

    // A write commits only at its completion edge and never when clr cancels it.
    assign ram_we_s = (state_r == ST_RESP) & op_wr_r & ~clr;

    // Next-state and latency-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (start_s) begin
                    cnt_nxt_s = CNT_INIT;
                    if (CNT_INIT == 4'd0) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // cnt was preloaded with LAT-1, so reaching 1 leaves exactly
                // one more edge before the RESP edge completes the access.
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Control state, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            read_prev_r  <= 1'b0;
            write_prev_r <= 1'b0;
            addr_r       <= '0;
            data_r       <= 32'd0;
            op_wr_r      <= 1'b0;
            Mdatain      <= 32'd0;
            Done         <= 1'b0;
            Busy         <= 1'b0;
            Err          <= 1'b0;
        end else begin
            // Strobe history updates every cycle so a held strobe never retriggers.
            read_prev_r  <= Read;
            write_prev_r <= Write;
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            if (start_s) begin
                addr_r  <= MARaddr;
                data_r  <= MDRdata;
                op_wr_r <= req_wr_s;
            end
            if ((state_r == ST_RESP) && !op_wr_r) begin
                Mdatain <= ram_r[addr_r];
            end
            Done <= (state_r == ST_RESP);
            Busy <= (state_nxt_s != ST_IDLE);
            Err  <= err_s;
        end
    end

    // RAM write port; contents are deliberately untouched by clr.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[addr_r] <= data_r;
        end
    end

endmodule
